// File: rtl/fifo_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer_pkg
// Brief    : Shared state encoding for the FIFO word packer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_word_packer_pkg;

    localparam logic [0:0] c_st_accum      = 1'b0;
    localparam logic [0:0] c_st_flush_pend = 1'b1;

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : stream_out_reg
// Brief    : Registered valid/ready output stage; payload holds while stalled.
// Revision : 1.0 - initial release
// ============================================================================
module stream_out_reg #(
    parameter int PAYLOAD_WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [PAYLOAD_WIDTH-1:0] i_payload,
    input  logic                     i_ready,
    output logic [PAYLOAD_WIDTH-1:0] o_payload,
    output logic                     o_valid
);

    logic [PAYLOAD_WIDTH-1:0] r_payload;
    logic                     r_valid;

    // A load wins over a same-cycle transfer so back-to-back words have no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_payload <= '0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_payload <= i_payload;
            r_valid   <= 1'b1;
        end else if (i_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_payload = r_payload;
    assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Drains a show-ahead FIFO and packs RATIO narrow words per output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATA_WIDTH-1:0]       fifo_data_i,
    input  logic                        fifo_empty_i,
    output logic                        fifo_rd_o,
    input  logic                        flush_i,
    output logic [DATA_WIDTH*RATIO-1:0] m_data_o,
    output logic [RATIO-1:0]            m_keep_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i
);

    localparam int OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int CNT_WIDTH = $clog2(RATIO);
    localparam int ACC_WIDTH = DATA_WIDTH * (RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(RATIO - 1);

    logic [CNT_WIDTH-1:0]       r_cnt;
    logic [0:0]                 r_state;
    logic [ACC_WIDTH-1:0]       r_acc;

    logic                       w_flush_pend;
    logic                       w_out_free;
    logic                       w_last;
    logic                       w_pop;
    logic                       w_word_done;
    logic                       w_flush_emit;
    logic                       w_flush_take;
    logic [RATIO-1:0]           w_flush_keep;
    logic [OUT_WIDTH-1:0]       w_load_data;
    logic [RATIO-1:0]           w_load_keep;
    logic [OUT_WIDTH+RATIO-1:0] w_payload;

    assign w_flush_pend = (r_state == c_st_flush_pend);
    assign w_out_free   = !m_valid_o || m_ready_i;
    assign w_last       = (r_cnt == c_last_cnt);
    assign w_pop        = !fifo_empty_i && !w_flush_pend && (!w_last || w_out_free);
    assign w_word_done  = w_pop && w_last;
    assign w_flush_emit = w_flush_pend && w_out_free;
    // An empty accumulator with no incoming word has nothing to flush.
    assign w_flush_take = flush_i && !w_flush_pend && !w_word_done
                          && ((r_cnt != '0) || w_pop);

    assign fifo_rd_o = w_pop && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_accum;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_accum: begin
                    if (w_word_done) begin
                        r_cnt <= '0;
                    end else if (w_pop) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                    if (w_flush_take) begin
                        r_state <= c_st_flush_pend;
                    end
                end
                c_st_flush_pend: begin
                    if (w_out_free) begin
                        r_cnt   <= '0;
                        r_state <= c_st_accum;
                    end
                end
                default: r_state <= c_st_accum;
            endcase
        end
    end

    // The final lane bypasses the accumulator and goes straight to the output.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_word_done || w_flush_emit) begin
            r_acc <= '0;
        end else if (w_pop) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                if (r_cnt == CNT_WIDTH'(i)) begin
                    r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_i;
                end
            end
        end
    end

    for (genvar k = 0; k < RATIO; k++) begin : g_keep
        assign w_flush_keep[k] = (CNT_WIDTH'(k) < r_cnt);
    end

    assign w_load_data = w_word_done ? {fifo_data_i, r_acc}
                                     : {{DATA_WIDTH{1'b0}}, r_acc};
    assign w_load_keep = w_word_done ? {RATIO{1'b1}} : w_flush_keep;

    stream_out_reg #(
        .PAYLOAD_WIDTH (OUT_WIDTH + RATIO)
    ) u_out_reg (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_load    (w_word_done || w_flush_emit),
        .i_payload ({w_load_keep, w_load_data}),
        .i_ready   (m_ready_i),
        .o_payload (w_payload),
        .o_valid   (m_valid_o)
    );

    assign m_keep_o = w_payload[OUT_WIDTH +: RATIO];
    assign m_data_o = w_payload[OUT_WIDTH-1:0];

endmodule
`default_nettype wire
